// File: rtl/seq_loader_if.sv
// Byte-stream input and sequence-RAM write bus of one sequence loader.
interface seq_loader_if #(parameter int N = 128);
   localparam int BIT = $clog2(N);

   logic           start;
   logic [7:0]     in_data;
   logic           in_valid;
   logic           in_ready;
   logic           ram_we;
   logic [BIT-1:0] ram_addr;
   logic [8:0]     ram_din;
   logic [BIT:0]   len;
   logic           done;
   logic           err;

   modport master (
      output start, in_data, in_valid,
      input  in_ready, ram_we, ram_addr, ram_din, len, done, err
   );

   modport slave (
      input  start, in_data, in_valid,
      output in_ready, ram_we, ram_addr, ram_din, len, done, err
   );
endinterface

// File: rtl/seq_loader.sv
// Loads an ASCII nucleotide stream into sequence RAM, uppercasing a/c/g/t,
// and reports length plus done/error status.
//
// state | meaning
// IDLE  | waiting for the first start after reset
// LOAD  | accepting bytes, writing nucleotides
// DONE  | newline or full RAM ended the sequence; len valid
// ERR   | non-nucleotide byte received; len holds count so far
module seq_loader #(
   parameter int N = 128
) (
   input logic        clk,
   input logic        rst,
   seq_loader_if.slave bus
);
   localparam int BIT = $clog2(N);
   localparam int CW  = BIT + 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LOAD = 2'd1;
   localparam logic [1:0] DONE = 2'd2;
   localparam logic [1:0] ERR  = 2'd3;

   logic [1:0]     state_q, state_d;
   logic [BIT:0]   count_q, count_d;
   logic [BIT:0]   len_q, len_d;
   logic           ram_we_q, ram_we_d;
   logic [BIT-1:0] ram_addr_q, ram_addr_d;
   logic [8:0]     ram_din_q, ram_din_d;

   logic           accept;
   logic           is_lower;
   logic           is_nuc;
   logic           is_nl;
   logic [7:0]     upper;
   logic [BIT:0]   count_inc;

   assign bus.in_ready = (state_q == LOAD);
   assign accept       = bus.in_valid && bus.in_ready;
   assign count_inc    = count_q + 1'b1;

   always_comb begin
      is_lower = (bus.in_data == 8'h61) || (bus.in_data == 8'h63) ||
                 (bus.in_data == 8'h67) || (bus.in_data == 8'h74);
      upper    = is_lower ? (bus.in_data - 8'h20) : bus.in_data;
      is_nuc   = (upper == 8'h41) || (upper == 8'h43) ||
                 (upper == 8'h47) || (upper == 8'h54);
      is_nl    = (bus.in_data == 8'h0A) || (bus.in_data == 8'h0D);
   end

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      len_d      = len_q;
      ram_we_d   = 1'b0;
      ram_addr_d = ram_addr_q;
      ram_din_d  = ram_din_q;

      // start wins over any byte handshaked in the same cycle.
      if (bus.start) begin
         state_d = LOAD;
         count_d = '0;
         len_d   = '0;
      end else if (state_q == LOAD && accept) begin
         if (is_nuc) begin
            ram_we_d   = 1'b1;
            ram_addr_d = count_q[BIT-1:0];
            ram_din_d  = {1'b0, upper};
            count_d    = count_inc;
            if (count_inc == CW'(N)) begin
               state_d = DONE;
               len_d   = count_inc;
            end
         end else if (is_nl) begin
            if (count_q != '0) begin
               state_d = DONE;
               len_d   = count_q;
            end
         end else begin
            state_d = ERR;
            len_d   = count_q;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         count_q    <= '0;
         len_q      <= '0;
         ram_we_q   <= 1'b0;
         ram_addr_q <= '0;
         ram_din_q  <= '0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         len_q      <= len_d;
         ram_we_q   <= ram_we_d;
         ram_addr_q <= ram_addr_d;
         ram_din_q  <= ram_din_d;
      end
   end

   assign bus.ram_we   = ram_we_q;
   assign bus.ram_addr = ram_addr_q;
   assign bus.ram_din  = ram_din_q;
   assign bus.len      = len_q;
   assign bus.done     = (state_q == DONE);
   assign bus.err      = (state_q == ERR);
endmodule

// File: tb/tb_seq_loader.sv
// Directed bench for seq_loader: a 128-deep instance and a 4-deep instance,
// each checked every cycle against a behavioural model plus literal write logs.
module tb_seq_loader;
   logic clk;
   logic rst;

   seq_loader_if #(.N(128)) if0 ();
   seq_loader_if #(.N(4))   if1 ();

   seq_loader #(.N(128)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
   seq_loader #(.N(4))   dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

   logic       s_start [2];
   logic       s_valid [2];
   logic [7:0] s_data  [2];

   assign if0.start = s_start[0];  assign if0.in_valid = s_valid[0];  assign if0.in_data = s_data[0];
   assign if1.start = s_start[1];  assign if1.in_valid = s_valid[1];  assign if1.in_data = s_data[1];

   logic       o_ready [2];
   logic       o_we    [2];
   logic [7:0] o_addr  [2];
   logic [8:0] o_din   [2];
   logic [7:0] o_len   [2];
   logic       o_done  [2];
   logic       o_err   [2];

   assign o_ready[0] = if0.in_ready;  assign o_ready[1] = if1.in_ready;
   assign o_we[0]    = if0.ram_we;    assign o_we[1]    = if1.ram_we;
   assign o_addr[0]  = 8'(if0.ram_addr); assign o_addr[1] = 8'(if1.ram_addr);
   assign o_din[0]   = if0.ram_din;   assign o_din[1]   = if1.ram_din;
   assign o_len[0]   = 8'(if0.len);   assign o_len[1]   = 8'(if1.len);
   assign o_done[0]  = if0.done;      assign o_done[1]  = if1.done;
   assign o_err[0]   = if0.err;       assign o_err[1]   = if1.err;

   int nchecks = 0;
   int nfail   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      nchecks++;
      if (act != exp) begin
         nfail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   // Model: status 0=idle 1=loading 2=finished 3=error.
   function automatic int depth(input int k);
      return (k == 0) ? 128 : 4;
   endfunction

   function automatic logic [7:0] to_upper(input logic [7:0] b);
      return (b >= "a" && b <= "z") ? b - 8'd32 : b;
   endfunction

   function automatic bit nucleotide(input logic [7:0] b);
      logic [7:0] u;
      u = to_upper(b);
      return (u == "A") || (u == "C") || (u == "G") || (u == "T");
   endfunction

   int         m_st   [2];
   int         m_cnt  [2];
   int         m_len  [2];
   bit         m_we   [2];
   int         m_addr [2];
   logic [8:0] m_din  [2];

   always @(posedge clk or posedge rst) begin
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m_st[k] <= 0; m_cnt[k] <= 0; m_len[k] <= 0;
            m_we[k] <= 1'b0; m_addr[k] <= 0; m_din[k] <= 9'd0;
         end else begin
            m_we[k] <= 1'b0;
            if (s_start[k]) begin
               m_st[k] <= 1; m_cnt[k] <= 0; m_len[k] <= 0;
            end else if (m_st[k] == 1 && s_valid[k]) begin
               if (nucleotide(s_data[k])) begin
                  m_we[k]   <= 1'b1;
                  m_addr[k] <= m_cnt[k];
                  m_din[k]  <= {1'b0, to_upper(s_data[k])};
                  m_cnt[k]  <= m_cnt[k] + 1;
                  if (m_cnt[k] + 1 == depth(k)) begin
                     m_st[k] <= 2; m_len[k] <= depth(k);
                  end
               end else if (s_data[k] == 8'h0A || s_data[k] == 8'h0D) begin
                  if (m_cnt[k] > 0) begin
                     m_st[k] <= 2; m_len[k] <= m_cnt[k];
                  end
               end else begin
                  m_st[k] <= 3; m_len[k] <= m_cnt[k];
               end
            end
         end
      end
   end

   logic [16:0] wlog0 [$];
   logic [16:0] wlog1 [$];

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("u%0d.in_ready", k), int'(o_ready[k]), (m_st[k] == 1) ? 1 : 0);
         chk($sformatf("u%0d.ram_we",   k), int'(o_we[k]),    int'(m_we[k]));
         chk($sformatf("u%0d.ram_addr", k), int'(o_addr[k]),  m_addr[k]);
         chk($sformatf("u%0d.ram_din",  k), int'(o_din[k]),   int'(m_din[k]));
         chk($sformatf("u%0d.len",      k), int'(o_len[k]),   m_len[k]);
         chk($sformatf("u%0d.done",     k), int'(o_done[k]),  (m_st[k] == 2) ? 1 : 0);
         chk($sformatf("u%0d.err",      k), int'(o_err[k]),   (m_st[k] == 3) ? 1 : 0);
         if (o_we[k]) begin
            if (k == 0) wlog0.push_back({o_addr[k], o_din[k]});
            else        wlog1.push_back({o_addr[k], o_din[k]});
         end
      end
   end

   task automatic cyc(input int k, input logic st, input logic v, input logic [7:0] d);
      s_start[k] = st;
      s_valid[k] = v;
      s_data[k]  = d;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int k, input string s, input bit gaps);
      for (int i = 0; i < s.len(); i++) begin
         cyc(k, 1'b0, 1'b1, s[i]);
         if (gaps) cyc(k, 1'b0, 1'b0, "Z");
      end
      cyc(k, 1'b0, 1'b0, 8'h00);
   endtask

   // Expected log: character i of exp written at address i, in order.
   task automatic expect_writes(input int k, input string tag, input string exp);
      logic [16:0] e;
      int n;
      n = (k == 0) ? wlog0.size() : wlog1.size();
      chk({tag, ".nwrites"}, n, exp.len());
      for (int i = 0; i < exp.len() && i < n; i++) begin
         e = (k == 0) ? wlog0[i] : wlog1[i];
         chk($sformatf("%s.addr%0d", tag, i), int'(e[16:9]), i);
         chk($sformatf("%s.din%0d",  tag, i), int'(e[8:0]),  int'(exp[i]));
      end
      if (k == 0) wlog0.delete(); else wlog1.delete();
   endtask

   task automatic status(input int k, input string tag, input int d, input int e, input int l);
      chk({tag, ".done"},  int'(o_done[k]),  d);
      chk({tag, ".err"},   int'(o_err[k]),   e);
      chk({tag, ".len"},   int'(o_len[k]),   l);
      chk({tag, ".ready"}, int'(o_ready[k]), 0);
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         s_start[k] = 1'b0; s_valid[k] = 1'b0; s_data[k] = 8'h00;
      end
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      status(0, "reset0", 0, 0, 0);
      status(1, "reset1", 0, 0, 0);
      chk("reset0.ram_we", int'(o_we[0]), 0);
      #3 rst = 1'b0;
      @(posedge clk); #1;

      // Basic stream
      cyc(0, 1'b1, 1'b0, 8'h00);
      send(0, "CACTG\n", 1'b0);
      cyc(0, 1'b0, 1'b0, 8'h00);
      expect_writes(0, "cactg", "CACTG");
      status(0, "cactg", 1, 0, 5);

      // Leading newlines, lowercase, gapped valid
      cyc(0, 1'b1, 1'b0, 8'h00);
      send(0, "\n\nga\n", 1'b1);
      expect_writes(0, "ga", "GA");
      status(0, "ga", 1, 0, 2);

      // Full at depth 4; fifth byte must not be accepted
      cyc(1, 1'b1, 1'b0, 8'h00);
      cyc(1, 1'b0, 1'b1, "A");
      cyc(1, 1'b0, 1'b1, "C");
      cyc(1, 1'b0, 1'b1, "G");
      cyc(1, 1'b0, 1'b1, "T");
      chk("full.ready_before_5th", int'(o_ready[1]), 0);
      cyc(1, 1'b0, 1'b1, "A");
      cyc(1, 1'b0, 1'b0, 8'h00);
      cyc(1, 1'b0, 1'b0, 8'h00);
      expect_writes(1, "full", "ACGT");
      status(1, "full", 1, 0, 4);

      // Invalid byte, then recovery
      cyc(0, 1'b1, 1'b0, 8'h00);
      send(0, "AC5G", 1'b0);
      expect_writes(0, "bad", "AC");
      status(0, "bad", 0, 1, 2);
      cyc(0, 1'b1, 1'b0, 8'h00);
      chk("recover.err_cleared", int'(o_err[0]), 0);
      send(0, "T\n", 1'b0);
      expect_writes(0, "recover", "T");
      status(0, "recover", 1, 0, 1);

      // Restart mid-load with a coincident byte
      cyc(0, 1'b1, 1'b0, 8'h00);
      send(0, "ACG", 1'b0);
      cyc(0, 1'b1, 1'b1, "T");
      cyc(0, 1'b0, 1'b0, 8'h00);
      expect_writes(0, "prerestart", "ACG");
      chk("restart.len", int'(o_len[0]), 0);
      send(0, "G\n", 1'b0);
      expect_writes(0, "restart", "G");
      status(0, "restart", 1, 0, 1);

      // Async reset between edges, with a write pulse in flight
      cyc(0, 1'b1, 1'b0, 8'h00);
      cyc(0, 1'b0, 1'b1, "A");
      cyc(0, 1'b0, 1'b1, "C");
      cyc(0, 1'b0, 1'b1, "G");
      chk("arst.we_before", int'(o_we[0]), 1);
      #2 rst = 1'b1;
      #1;
      chk("arst.ready", int'(o_ready[0]), 0);
      chk("arst.ram_we", int'(o_we[0]), 0);
      chk("arst.done", int'(o_done[0]), 0);
      chk("arst.err", int'(o_err[0]), 0);
      chk("arst.len", int'(o_len[0]), 0);
      chk("arst.u1_done", int'(o_done[1]), 0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk); #1;
      cyc(0, 1'b0, 1'b1, "G");
      cyc(0, 1'b0, 1'b1, "T");
      cyc(0, 1'b0, 1'b1, "\n");
      cyc(0, 1'b0, 1'b0, 8'h00);
      expect_writes(0, "arst", "AC");
      expect_writes(1, "idle1", "");
      chk("arst.idle_ready", int'(o_ready[0]), 0);

      $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
      $finish;
   end
endmodule
